// File: rtl/pkg_en.sv
// Shared widths and token types for the external-memory port family.
package pkg_en;

    localparam int WIDTH_DATA   = 16;
    localparam int WIDTH_EXADDR = 16;

    // Forward data token: valid, first-of-stream, reserved/control flags, index, data
    typedef struct packed {
        logic                    v;
        logic                    a;
        logic                    r;
        logic                    c;
        logic [WIDTH_EXADDR-1:0] i;
        logic [WIDTH_DATA-1:0]   d;
    } FTk_t;

    // Backward token: n = not ready (stall)
    typedef struct packed {
        logic n;
    } BTk_t;

endpackage

// File: rtl/ext_mem_boot_port_if.sv
// Load/store/boot handshake bundle between a requester (master) and ext_mem_boot_port (slave).
interface ext_mem_boot_port_if;

    logic          I_Boot;
    logic          O_Ld_Rdy;
    logic          I_Ld_Req;
    logic [pkg_en::WIDTH_EXADDR-1:0] I_Ld_Addr;
    pkg_en::FTk_t  O_Ld_FTk;
    pkg_en::BTk_t  I_Ld_BTk;
    logic          I_St_Req;
    logic [pkg_en::WIDTH_EXADDR-1:0] I_St_Addr;
    pkg_en::FTk_t  I_St_FTk;
    pkg_en::BTk_t  O_St_BTk;
    logic          O_Busy;

    modport slave (
        input  I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk,
        output O_Ld_Rdy, O_Ld_FTk, O_St_BTk, O_Busy
    );

    modport master (
        output I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk,
        input  O_Ld_Rdy, O_Ld_FTk, O_St_BTk, O_Busy
    );

endinterface

// File: rtl/ext_mem_boot_port.sv
// Word memory with a one-shot boot stream (zero pad + mem[0..NUM_BOOT-1]) followed by
// a stallable RD_LAT-deep load pipeline and a single-cycle store port.
module ext_mem_boot_port
    import pkg_en::*;
#(
    parameter int WIDTH_DATA   = pkg_en::WIDTH_DATA,
    parameter int WIDTH_EXADDR = pkg_en::WIDTH_EXADDR,
    parameter int DEPTH_MEM    = 1024,
    parameter int BOOT_PAD     = 3,
    parameter int NUM_BOOT     = 5,
    parameter int RD_LAT       = 1,
    parameter int IDX_MODE     = 0
) (
    input  logic               clock,
    input  logic               reset,
    ext_mem_boot_port_if.slave bus
);

    localparam int TOTAL = BOOT_PAD + NUM_BOOT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int MW    = $clog2(DEPTH_MEM);
    localparam int L     = RD_LAT - 1;
    localparam logic [CW-1:0]           TOTAL_C  = CW'(TOTAL);
    localparam logic [CW-1:0]           PAD_C    = CW'(BOOT_PAD);
    localparam logic [WIDTH_EXADDR-1:0] DEPTH_A  = WIDTH_EXADDR'(DEPTH_MEM);
    localparam FTk_t                    TOK_ZERO = {$bits(FTk_t){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    FTk_t                    pipe_r [RD_LAT];
    FTk_t                    pipe_s [RD_LAT];
    logic                    st_n_r;
    logic                    busy_r, busy_s;
    logic [WIDTH_DATA-1:0]   mem_r [DEPTH_MEM];

    logic                    stall_s, ld_acc_s, st_we_s;
    logic [CW-1:0]           boot_idx_s, boot_off_s;
    logic [WIDTH_EXADDR-1:0] ld_addr_s, st_addr_s;
    FTk_t                    boot_tok_s, ld_tok_s;
    logic                    unused_s;

    assign unused_s = ^{bus.I_St_FTk.a, bus.I_St_FTk.r, bus.I_St_FTk.c, bus.I_St_FTk.i};

    // Candidate tokens for the boot stream and for a load issued this cycle (read-first)
    always_comb begin
        stall_s    = bus.I_Ld_BTk.n;
        ld_addr_s  = bus.I_Ld_Addr;
        st_addr_s  = bus.I_St_Addr;
        boot_idx_s = (state_r == ST_BOOT) ? cnt_r : {CW{1'b0}};
        boot_off_s = boot_idx_s - PAD_C;

        boot_tok_s   = TOK_ZERO;
        boot_tok_s.v = 1'b1;
        boot_tok_s.a = (boot_idx_s == {CW{1'b0}});
        if (boot_idx_s >= PAD_C) begin
            boot_tok_s.d = mem_r[MW'(boot_off_s)];
        end else begin
            boot_tok_s.d = {WIDTH_DATA{1'b0}};
        end

        ld_tok_s   = TOK_ZERO;
        ld_tok_s.v = 1'b1;
        if (IDX_MODE == 1) begin
            ld_tok_s.i = ld_addr_s;
        end else begin
            ld_tok_s.i = {WIDTH_EXADDR{1'b0}};
        end
        // Out-of-range loads still produce a valid token, just with zero data
        if (ld_addr_s < DEPTH_A) begin
            ld_tok_s.d = mem_r[ld_addr_s[MW-1:0]];
        end else begin
            ld_tok_s.d = {WIDTH_DATA{1'b0}};
        end

        ld_acc_s = (state_r == ST_RUN) & bus.I_Ld_Req & ~stall_s;
        st_we_s  = (state_r == ST_RUN) & bus.I_St_Req & bus.I_St_FTk.v & (st_addr_s < DEPTH_A);
    end

    // Next-state logic: boot sequencing, pipeline advance and busy flag
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pipe_s  = pipe_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.I_Boot) begin
                    state_s   = ST_BOOT;
                    cnt_s     = CW'(1);
                    pipe_s[L] = boot_tok_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BOOT: begin
                // cnt_r counts words already placed on the output; the last one leaves when unstalled
                if (stall_s) begin
                    state_s = ST_BOOT;
                end else if (cnt_r == TOTAL_C) begin
                    state_s   = ST_RUN;
                    pipe_s[L] = TOK_ZERO;
                end else begin
                    pipe_s[L] = boot_tok_s;
                    cnt_s     = cnt_r + CW'(1);
                end
            end
            ST_RUN: begin
                if (stall_s) begin
                    state_s = ST_RUN;
                end else begin
                    for (int i = RD_LAT - 1; i > 0; i--) begin
                        pipe_s[i] = pipe_r[i-1];
                    end
                    pipe_s[0] = ld_acc_s ? ld_tok_s : TOK_ZERO;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s == ST_BOOT);
        for (int i = 0; i < RD_LAT; i++) begin
            busy_s = busy_s | pipe_s[i].v;
        end
    end

    // State, pipeline and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_r[i] <= TOK_ZERO;
            end
            st_n_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_s[i];
            end
            st_n_r  <= (state_s != ST_RUN);
            busy_r  <= busy_s;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clock) begin
        if (st_we_s) begin
            mem_r[st_addr_s[MW-1:0]] <= bus.I_St_FTk.d;
        end
    end

    assign bus.O_Ld_FTk = pipe_r[L];
    assign bus.O_Ld_Rdy = (state_r == ST_RUN) & ~stall_s;
    assign bus.O_St_BTk = BTk_t'(st_n_r);
    assign bus.O_Busy   = busy_r;

endmodule

// File: tb/tb_ext_mem_boot_port.sv
// Directed bench for ext_mem_boot_port with RD_LAT=3, IDX_MODE=1: boot stream, load pipeline,
// stall, read-first collision, out-of-range accesses and reset during boot.
module tb_ext_mem_boot_port;
    import pkg_en::*;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    ext_mem_boot_port_if bus ();

    ext_mem_boot_port #(.RD_LAT(3), .IDX_MODE(1)) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] VA = 16'hA1A1;
    localparam logic [15:0] VB = 16'hB2B2;
    localparam logic [15:0] VC = 16'hC3C3;
    logic [15:0] boot_d [8] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    FTk_t zero_tok = '0;

    function automatic FTk_t tok(input logic fa, input logic [15:0] fi, input logic [15:0] fd);
        tok = '{v: 1'b1, a: fa, r: 1'b0, c: 1'b0, i: fi, d: fd};
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.I_Boot    = 1'b0;
        bus.I_Ld_Req  = 1'b0;
        bus.I_Ld_Addr = 16'd0;
        bus.I_Ld_BTk  = '{n: 1'b0};
        bus.I_St_Req  = 1'b0;
        bus.I_St_Addr = 16'd0;
        bus.I_St_FTk  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int k = 0; k < 1024; k++) dut.mem_r[k] = 16'd0;
        for (int k = 0; k < 5; k++) dut.mem_r[k] = 16'(k + 1);
        dut.mem_r[7]  = 16'h0001;
        dut.mem_r[10] = VA;
        dut.mem_r[11] = VB;
        dut.mem_r[12] = VC;
        repeat (2) step();
        checks++; if (bus.O_Ld_FTk !== zero_tok) begin errors++; $display("FAIL reset_ftk got %h want %h", bus.O_Ld_FTk, zero_tok); end
        checks++; if (bus.O_Ld_Rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", bus.O_Ld_Rdy); end
        checks++; if (bus.O_St_BTk.n !== 1'b1) begin errors++; $display("FAIL reset_st_n got %b want 1", bus.O_St_BTk.n); end
        checks++; if (bus.O_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.O_Busy); end
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (bus.O_Ld_FTk.v !== 1'b0 || bus.O_Busy !== 1'b0) begin errors++; $display("FAIL idle_wait got v=%b busy=%b want 0 0", bus.O_Ld_FTk.v, bus.O_Busy); end
    endtask

    // Runs a full boot, optionally exercising boot-time stall, store and stray I_Boot
    task automatic run_boot(input bit extras, input string tag);
        FTk_t st_tok;
        bus.I_Boot = 1'b1;
        step();
        bus.I_Boot = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.O_Ld_FTk !== tok(k == 0, 16'd0, boot_d[k])) begin errors++; $display("FAIL %s_word%0d got %h want %h", tag, k, bus.O_Ld_FTk, tok(k == 0, 16'd0, boot_d[k])); end
            checks++; if (bus.O_Busy !== 1'b1 || bus.O_St_BTk.n !== 1'b1 || bus.O_Ld_Rdy !== 1'b0) begin errors++; $display("FAIL %s_status%0d got busy=%b st_n=%b rdy=%b want 1 1 0", tag, k, bus.O_Busy, bus.O_St_BTk.n, bus.O_Ld_Rdy); end
            if (extras && k == 1) begin
                st_tok = '0; st_tok.v = 1'b1; st_tok.d = 16'hFFFF;
                bus.I_St_Req = 1'b1; bus.I_St_Addr = 16'd2; bus.I_St_FTk = st_tok;
                bus.I_Boot = 1'b1;
            end
            if (extras && k == 2) begin
                bus.I_St_Req = 1'b0; bus.I_St_FTk = '0; bus.I_Boot = 1'b0;
                bus.I_Ld_BTk = '{n: 1'b1};
                step();
                checks++; if (bus.O_Ld_FTk !== tok(1'b0, 16'd0, boot_d[2])) begin errors++; $display("FAIL boot_stall_hold got %h want %h", bus.O_Ld_FTk, tok(1'b0, 16'd0, boot_d[2])); end
                bus.I_Ld_BTk = '{n: 1'b0};
            end
            step();
        end
        checks++; if (bus.O_Ld_FTk !== zero_tok || bus.O_Busy !== 1'b0) begin errors++; $display("FAIL %s_end got ftk=%h busy=%b want 0 0", tag, bus.O_Ld_FTk, bus.O_Busy); end
        checks++; if (bus.O_St_BTk.n !== 1'b0 || bus.O_Ld_Rdy !== 1'b1) begin errors++; $display("FAIL %s_run got st_n=%b rdy=%b want 0 1", tag, bus.O_St_BTk.n, bus.O_Ld_Rdy); end
    endtask

    task automatic test_boot();
        run_boot(1'b1, "boot");
    endtask

    task automatic test_load_pipe();
        logic [15:0] exp_d [3] = '{VA, VB, VC};
        for (int s = 0; s < 7; s++) begin
            if (s >= 3 && s <= 5) begin
                checks++; if (bus.O_Ld_FTk !== tok(1'b0, 16'(7 + s), exp_d[s-3])) begin errors++; $display("FAIL pipe_out%0d got %h want %h", s, bus.O_Ld_FTk, tok(1'b0, 16'(7 + s), exp_d[s-3])); end
            end else begin
                checks++; if (bus.O_Ld_FTk !== zero_tok) begin errors++; $display("FAIL pipe_empty%0d got %h want 0", s, bus.O_Ld_FTk); end
            end
            checks++; if (bus.O_Busy !== (s >= 1 && s <= 5)) begin errors++; $display("FAIL pipe_busy%0d got %b want %b", s, bus.O_Busy, (s >= 1 && s <= 5)); end
            bus.I_Ld_Req  = (s < 3);
            bus.I_Ld_Addr = (s < 3) ? 16'(10 + s) : 16'd0;
            step();
        end
    endtask

    task automatic test_stall();
        FTk_t exp_t [9];
        logic exp_rdy;
        for (int s = 0; s < 9; s++) exp_t[s] = zero_tok;
        exp_t[3] = tok(1'b0, 16'd10, VA);
        exp_t[4] = tok(1'b0, 16'd10, VA);
        exp_t[5] = tok(1'b0, 16'd10, VA);
        exp_t[6] = tok(1'b0, 16'd11, VB);
        exp_t[7] = tok(1'b0, 16'd12, VC);
        for (int s = 0; s < 9; s++) begin
            exp_rdy = !(s == 4 || s == 5);
            checks++; if (bus.O_Ld_FTk !== exp_t[s]) begin errors++; $display("FAIL stall_out%0d got %h want %h", s, bus.O_Ld_FTk, exp_t[s]); end
            checks++; if (bus.O_Ld_Rdy !== exp_rdy) begin errors++; $display("FAIL stall_rdy%0d got %b want %b", s, bus.O_Ld_Rdy, exp_rdy); end
            bus.I_Ld_Req  = (s < 3) || (s == 4);
            bus.I_Ld_Addr = (s < 3) ? 16'(10 + s) : 16'd7;
            if (s == 3) bus.I_Ld_BTk = '{n: 1'b1};
            if (s == 5) bus.I_Ld_BTk = '{n: 1'b0};
            step();
        end
    endtask

    task automatic test_read_first();
        FTk_t st_tok;
        st_tok = '0; st_tok.v = 1'b1; st_tok.d = 16'hDEAD;
        bus.I_St_Req = 1'b1; bus.I_St_Addr = 16'd7; bus.I_St_FTk = st_tok;
        bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = 16'd7;
        step();
        bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
        step();
        bus.I_Ld_Req = 1'b0;
        step();
        checks++; if (bus.O_Ld_FTk !== tok(1'b0, 16'd7, 16'h0001)) begin errors++; $display("FAIL rf_old got %h want %h", bus.O_Ld_FTk, tok(1'b0, 16'd7, 16'h0001)); end
        step();
        checks++; if (bus.O_Ld_FTk !== tok(1'b0, 16'd7, 16'hDEAD)) begin errors++; $display("FAIL rf_new got %h want %h", bus.O_Ld_FTk, tok(1'b0, 16'd7, 16'hDEAD)); end
        step();
    endtask

    task automatic test_out_of_range();
        FTk_t st_tok;
        logic [15:0] addrs [3] = '{16'd1024, 16'd0, 16'd2};
        logic [15:0] exp_d [3] = '{16'd0, 16'd1, 16'd3};
        st_tok = '0; st_tok.v = 1'b1; st_tok.d = 16'hBEEF;
        bus.I_St_Req = 1'b1; bus.I_St_Addr = 16'd1024; bus.I_St_FTk = st_tok;
        step();
        bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
        for (int s = 0; s < 6; s++) begin
            if (s >= 3) begin
                checks++; if (bus.O_Ld_FTk !== tok(1'b0, addrs[s-3], exp_d[s-3])) begin errors++; $display("FAIL oob_load%0d got %h want %h", s - 3, bus.O_Ld_FTk, tok(1'b0, addrs[s-3], exp_d[s-3])); end
            end
            bus.I_Ld_Req  = (s < 3);
            bus.I_Ld_Addr = (s < 3) ? addrs[s] : 16'd0;
            step();
        end
        checks++; if (bus.O_Ld_FTk !== zero_tok) begin errors++; $display("FAIL oob_drain got %h want 0", bus.O_Ld_FTk); end
    endtask

    task automatic test_reset_midboot();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.I_Boot = 1'b1;
        step();
        bus.I_Boot = 1'b0;
        repeat (4) step();
        checks++; if (bus.O_Ld_FTk !== tok(1'b0, 16'd0, 16'd2)) begin errors++; $display("FAIL mid_word4 got %h want %h", bus.O_Ld_FTk, tok(1'b0, 16'd0, 16'd2)); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.O_Ld_FTk !== zero_tok || bus.O_Busy !== 1'b0) begin errors++; $display("FAIL mid_async got ftk=%h busy=%b want 0 0", bus.O_Ld_FTk, bus.O_Busy); end
        checks++; if (bus.O_St_BTk.n !== 1'b1 || bus.O_Ld_Rdy !== 1'b0) begin errors++; $display("FAIL mid_async_ctl got st_n=%b rdy=%b want 1 0", bus.O_St_BTk.n, bus.O_Ld_Rdy); end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (bus.O_Ld_FTk !== zero_tok || bus.O_Busy !== 1'b0) begin errors++; $display("FAIL mid_idle got ftk=%h busy=%b want 0 0", bus.O_Ld_FTk, bus.O_Busy); end
        run_boot(1'b0, "reboot");
    endtask

    initial begin
        test_reset();
        test_boot();
        test_load_pipe();
        test_stall();
        test_read_first();
        test_out_of_range();
        test_reset_midboot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_mem_boot_port.md
EXT_MEM_BOOT_PORT -- requirements
Module: ext_mem_boot_port

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  WIDTH_DATA, pkg_en value, data word width
  WIDTH_EXADDR, pkg_en value, external address width
  DEPTH_MEM, 1024, storage words
  BOOT_PAD, 3, leading zero-data boot words
  NUM_BOOT, 5, boot words taken from mem[0..NUM_BOOT-1]
  RD_LAT, 1, load latency in cycles, legal 1..4
  IDX_MODE, 0, 1 = drive FTk.i with the load address, 0 = FTk.i tied to 0
REQ-002 Ports (name, direction, width, meaning):
  clock, in, 1, single clock
  reset, in, 1, asynchronous, active-low
  I_Boot, in, 1, boot start pulse
  O_Ld_Rdy, out, 1, load request accepted this cycle
  I_Ld_Req, in, 1, load request
  I_Ld_Addr, in, WIDTH_EXADDR, load address
  O_Ld_FTk, out, FTk_t, load data token
  I_Ld_BTk, in, BTk_t, load backpressure (.n = stall)
  I_St_Req, in, 1, store request
  I_St_Addr, in, WIDTH_EXADDR, store address
  I_St_FTk, in, FTk_t, store data token
  O_St_BTk, out, BTk_t, store backpressure
  O_Busy, out, 1, boot in progress or load pipeline non-empty

Function
REQ-003 FSM states: IDLE, BOOT, RUN. IDLE->BOOT on I_Boot=1. BOOT->RUN after BOOT_PAD+NUM_BOOT words. RUN is terminal; I_Boot is ignored in BOOT and RUN.
REQ-004 BOOT, word k (k=0..BOOT_PAD+NUM_BOOT-1), one per cycle, starting the cycle after I_Boot:
  O_Ld_FTk.v=1
  .a=1 only for k=0
  .r=0, .c=0, .i=0
  .d=0 for k<BOOT_PAD, else mem[k-BOOT_PAD]
REQ-005 I_Ld_BTk.n=1 in BOOT holds the current word and k. Boot words are never dropped.
REQ-006 RUN: O_Ld_Rdy = ~I_Ld_BTk.n. A request is accepted when I_Ld_Req & O_Ld_Rdy.
REQ-007 An accepted load presents O_Ld_FTk exactly RD_LAT unstalled cycles later:
  .v=1, .a=.r=.c=0
  .d=mem[addr]
  .i=addr if IDX_MODE=1, else 0
REQ-008 Load pipeline: RD_LAT stages. I_Ld_BTk.n=1 freezes every stage and the output token. No token is lost or duplicated. Full throughput is one load per cycle.
REQ-009 In any cycle without a valid output token, O_Ld_FTk.v=0 and the other fields are 0.
REQ-010 A store commits mem[I_St_Addr] <= I_St_FTk.d when I_St_Req & I_St_FTk.v & ~O_St_BTk.n.
REQ-011 O_St_BTk.n=1 in IDLE and BOOT, so stores are rejected. In RUN, O_St_BTk='0.
REQ-012 Store and load to the same address in the same cycle: read-first. The load returns the pre-store value.
REQ-013 Address >= DEPTH_MEM: a load returns .d=0 with .v=1; a store is dropped.
REQ-014 O_Busy = (state==BOOT) | any valid pipeline stage.
REQ-015 Memory is initialised only by the simulation/bench load path and is not cleared by reset.

Reset
REQ-016 reset=0 asynchronously forces:
  state=IDLE, boot counter=0
  all pipeline valids=0
  O_Ld_FTk='0, O_Ld_Rdy=0
  O_St_BTk.n=1, O_Busy=0
REQ-017 Reset asserted mid-BOOT or mid-load discards all in-flight tokens. After release the block waits in IDLE for a new I_Boot.

Verification
REQ-018 Boot, defaults, mem[0..4]=1..5, pulse I_Boot -> 8 valid words; d = 0,0,0,1,2,3,4,5; a=1 on the first word only; then RUN.
REQ-019 RD_LAT=3, loads to addresses 10,11,12 on consecutive cycles with mem[10..12]=A,B,C -> v=1 with d=A,B,C on cycles +3,+4,+5; with IDX_MODE=1, i=10,11,12.
REQ-020 I_Ld_BTk.n=1 for 2 cycles in mid-stream -> output is held; O_Ld_Rdy=0; the sequence A,B,C resumes intact with no gap or duplicate.
REQ-021 In RUN, same-cycle store 0xDEAD to address 7 and load of address 7 (old value 0x1) -> load returns 0x1; a following load returns 0xDEAD.
REQ-022 Store attempted in BOOT -> O_St_BTk.n=1 and mem unchanged; a store to address DEPTH_MEM in RUN -> ignored.
REQ-023 reset low on boot word 4 -> outputs reach reset values immediately; after re-boot, the word stream restarts from k=0.
